// File: rtl/result_check.sv
// Result checker: pops expected/actual vector pairs, masks and compares them,
// keeps pass/fail counts and writes a 4-word record per failure to memory.
module result_check #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH = DATA_WIDTH / 8,
    parameter int STF_WIDTH = 24,
    parameter int CHF_WIDTH = STF_WIDTH + ADDR_WIDTH,
    parameter int SCC_WIDTH = 5,
    parameter int SCD_WIDTH = 24,
    parameter int CNT_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] LOG_BASE = 20'h80000,
    parameter int LOG_RECORDS = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [CHF_WIDTH-1:0]  cfifo_data,
    output logic                  cfifo_rdreq,
    input  logic                  cfifo_rdempty,
    input  logic [STF_WIDTH-1:0]  rfifo_data,
    output logic                  rfifo_rdreq,
    input  logic                  rfifo_rdempty,
    input  logic [SCC_WIDTH-1:0]  sc_cmd,
    input  logic [SCD_WIDTH-1:0]  sc_data,
    output logic                  sc_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [BE_WIDTH-1:0]   mem_byteenable,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    input  logic                  mem_waitrequest,
    output logic [CNT_WIDTH-1:0]  pass_count,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic                  log_overflow,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, POP, CMP, LOG} state_t;

    localparam logic [SCC_WIDTH-1:0]  CMD_MASK = SCC_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   LOG_LIM  = (ADDR_WIDTH+1)'(LOG_RECORDS);

    state_t                  state, state_nx;
    logic [STF_WIDTH-1:0]    mask;
    logic [STF_WIDTH-1:0]    act_q;
    logic [ADDR_WIDTH-1:0]   vaddr_q;
    logic [ADDR_WIDTH-1:0]   rec_addr;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [1:0]              word;
    logic [STF_WIDTH-1:0]    expected;
    logic                    mismatch;
    logic                    room;
    logic                    accept;
    logic                    last;

    assign expected = cfifo_data[CHF_WIDTH-1:ADDR_WIDTH];
    assign mismatch = |((expected ^ rfifo_data) & mask);
    assign room     = {1'b0, ptr} < LOG_LIM;
    assign accept   = mem_write && !mem_waitrequest;
    assign last     = accept && (word == 2'd3);
    assign done     = (state == IDLE) && cfifo_rdempty && rfifo_rdempty;

    assign mem_byteenable = '1;
    assign mem_address    = rec_addr + ADDR_WIDTH'(word);

    always_comb begin
        unique case (word)
            2'd0: mem_writedata = DATA_WIDTH'(vaddr_q[ADDR_WIDTH-1:16]);
            2'd1: mem_writedata = vaddr_q[15:0];
            2'd2: mem_writedata = DATA_WIDTH'(act_q[STF_WIDTH-1:16]);
            2'd3: mem_writedata = act_q[15:0];
        endcase
    end

    always_comb begin
        state_nx    = state;
        sc_ready    = 1'b0;
        cfifo_rdreq = 1'b0;
        rfifo_rdreq = 1'b0;
        mem_write   = 1'b0;
        unique case (state)
            IDLE: begin
                sc_ready = 1'b1;
                // A pending command takes the cycle; popping waits a turn.
                if (sc_cmd != CMD_MASK && !cfifo_rdempty && !rfifo_rdempty)
                    state_nx = POP;
            end
            POP: begin
                cfifo_rdreq = 1'b1;
                rfifo_rdreq = 1'b1;
                state_nx    = CMP;
            end
            CMP: begin
                state_nx = (mismatch && room) ? LOG : IDLE;
            end
            LOG: begin
                mem_write = 1'b1;
                if (last)
                    state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mask     <= '1;
            act_q    <= '0;
            vaddr_q  <= '0;
            rec_addr <= '0;
            word     <= '0;
        end else begin
            if (state == IDLE && sc_cmd == CMD_MASK)
                mask <= sc_data[STF_WIDTH-1:0];
            // Record address is frozen here so a clear mid-record cannot move it.
            if (state == CMP) begin
                act_q    <= rfifo_data;
                vaddr_q  <= cfifo_data[ADDR_WIDTH-1:0];
                rec_addr <= LOG_BASE + (ptr << 2);
                word     <= '0;
            end else if (accept) begin
                word <= word + 2'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pass_count   <= '0;
            fail_count   <= '0;
            log_overflow <= 1'b0;
            ptr          <= '0;
        end else if (clear) begin
            pass_count   <= '0;
            fail_count   <= '0;
            log_overflow <= 1'b0;
            ptr          <= '0;
        end else begin
            if (state == CMP) begin
                if (!mismatch) begin
                    if (pass_count != '1)
                        pass_count <= pass_count + CNT_ONE;
                end else begin
                    if (fail_count != '1)
                        fail_count <= fail_count + CNT_ONE;
                    if (!room)
                        log_overflow <= 1'b1;
                end
            end
            if (last)
                ptr <= ptr + PTR_ONE;
        end
    end

endmodule

// File: doc/result_check.md
Name: result_check

Overview:
- Consumer end of the CHECK_FIFO and responder end of the CHECK<=>STIM command interface.
- Pops each expected-result record (expected vector plus vector address) together with the matching captured DUT output vector from the result FIFO.
- Applies the current output bitmask, compares, and keeps pass/fail counts.
- Writes a 4-word failure record for every mismatch into a memory log region through an Avalon MM write master to mem_if.

Parameters:
ADDR_WIDTH, 20, memory word address width, also the vector address field width
DATA_WIDTH, 16, memory data width
BE_WIDTH, DATA_WIDTH/8, byteenable width
STF_WIDTH, 24, test vector width
CHF_WIDTH, STF_WIDTH+ADDR_WIDTH, CHECK_FIFO word width
SCC_WIDTH, 5, sc_cmd width
SCD_WIDTH, 24, sc_data width
CNT_WIDTH, 16, pass/fail counter width
LOG_BASE, 20'h80000, word address of the first failure record
LOG_RECORDS, 256, maximum number of failure records (power of 2)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous pulse: zero counters, log pointer, overflow flag
cfifo_data  in  CHF_WIDTH  [43:20] expected vector, [19:0] vector address
cfifo_rdreq  out  1  CHECK_FIFO read request
cfifo_rdempty  in  1  CHECK_FIFO empty
rfifo_data  in  STF_WIDTH  captured DUT output vector
rfifo_rdreq  out  1  result FIFO read request
rfifo_rdempty  in  1  result FIFO empty
sc_cmd  in  SCC_WIDTH  00000 idle, 00001 load bitmask
sc_data  in  SCD_WIDTH  bitmask value
sc_ready  out  1  ready to accept sc_cmd
mem_address  out  ADDR_WIDTH  write address
mem_byteenable  out  BE_WIDTH  always all ones
mem_write  out  1  write strobe
mem_writedata  out  DATA_WIDTH  write data
mem_waitrequest  in  1  slave stall
pass_count  out  CNT_WIDTH  matching vectors, saturating
fail_count  out  CNT_WIDTH  mismatching vectors, saturating
log_overflow  out  1  a failure was not logged because the log was full
done  out  1  idle and both FIFOs empty

Behaviour:
- FIFOs are in normal (non-show-ahead) mode: data is valid the cycle after rdreq.

Reset values:
- State IDLE.
- Bitmask 24'hFFFFFF.
- Counters 0, log pointer 0, log_overflow 0.
- mem_write 0, both rdreq 0, sc_ready 1.

IDLE:
- sc_ready=1. sc_ready is 1 only in IDLE.
- sc_cmd==BITMASK: latch sc_data into the bitmask at that edge and stay in IDLE. No pop this cycle; a command has priority over a pop.
- Otherwise, if ~cfifo_rdempty && ~rfifo_rdempty: go to POP.
- Never pop one FIFO without the other.

POP:
- cfifo_rdreq=rfifo_rdreq=1 for exactly one cycle, then go to CMP.

CMP:
- Latch expected, vector address and actual.
- mismatch = |((expected ^ actual) & bitmask).
- Match: pass_count+1, go to IDLE.
- Mismatch: fail_count+1.
  - If log pointer < LOG_RECORDS: go to LOG.
  - Else: set log_overflow and go to IDLE.

LOG:
- Issue 4 writes at LOG_BASE + 4*ptr + k, for k = 0..3:
  - w0 = {12'h000, vaddr[19:16]}
  - w1 = vaddr[15:0]
  - w2 = {8'h00, actual[23:16]}
  - w3 = actual[15:0]
- mem_write, address and data are held stable while mem_waitrequest=1. A word advances only on mem_write && ~mem_waitrequest.
- After the 4th accepted word: ptr+1, go to IDLE.
- Throughput for a pass: 3 cycles per vector (IDLE, POP, CMP).

Counters:
- Saturate at all ones; no wrap.
- Log pointer is ADDR_WIDTH wide and never wraps: once full, logging stops and overflow is set. The overflow flag is sticky.

clear:
- In any state, zeroes counters, log pointer and overflow.
- Does not abort an in-flight LOG; the record being written completes.
- clear together with a count increment in the same cycle: clear wins.

Other rules:
- done = (state==IDLE) && cfifo_rdempty && rfifo_rdempty.
- Unknown sc_cmd codes are ignored.
- reset mid-LOG: mem_write drops to 0 immediately (asynchronous). The partial record is abandoned, and the pointer returns to 0.

Test Plan:
- Expected 24'hA5A5A5, actual 24'hA5A5A5, default mask -> pass_count=1, fail_count=0, no mem_write, done=1 afterwards.
- Expected 24'h000001, actual 24'h000000, vaddr 20'h12345 -> fail_count=1. Writes at 80000..80003 of 0001, 2345, 0000, 0000.
- Bitmask 24'hFFFFFE loaded via sc_cmd=1, then the same vectors as the previous scenario -> pass_count=1, no write. A bitmask command issued while not in IDLE sees sc_ready=0.
- mem_waitrequest held high 5 cycles on w1 of a failure record -> address and data stable for those 5 cycles, the record completes, log pointer=1.
- LOG_RECORDS=2 with 3 mismatches -> exactly 8 writes, fail_count=3, log_overflow=1; a subsequent clear zeroes all of them.
- cfifo non-empty, rfifo empty -> no rdreq on either FIFO. Asserting reset mid-LOG -> mem_write=0 immediately, counters 0.
